// File: rtl/conv_layer_sched.sv
// conv_layer_sched: sequences one conv engine over all (oc, ic) pairs of a layer.
module conv_layer_sched #(
  parameter int CH_W    = 8,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CH_W-1:0] cfg_in_ch,
  input  logic [CH_W-1:0] cfg_out_ch,
  output logic            idle,
  output logic            done,
  output logic            err,
  output logic            eng_start,
  input  logic            eng_idle,
  input  logic            eng_finish,
  output logic [CH_W-1:0] ic_idx,
  output logic [CH_W-1:0] oc_idx,
  output logic            bias_en,
  output logic            acc_en,
  output logic            acc_load,
  output logic            och_valid,
  input  logic            och_ready
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACC, OUT, DONE} state_t;
  state_t state, nxt;
  logic [CH_W-1:0] in_ch, out_ch, ic_n, oc_n;
  logic [TO_W-1:0] wd;
  logic wd_hit;
  assign wd_hit = wd == TO_W'(TIMEOUT - 1);
  always_comb begin
    nxt  = state;
    ic_n = ic_idx;
    oc_n = oc_idx;
    case (state)
      IDLE: if (start) begin
        nxt  = (cfg_in_ch == '0 || cfg_out_ch == '0) ? DONE : ISSUE;
        ic_n = '0;
        oc_n = '0;
      end
      ISSUE: nxt = eng_idle ? WAIT : ISSUE;
      WAIT: nxt = eng_finish ? ACC : wd_hit ? DONE : WAIT;
      ACC: if (ic_idx < in_ch - 1'b1) begin
        ic_n = ic_idx + 1'b1;
        nxt  = ISSUE;
      end else nxt = OUT;
      OUT: if (och_ready) begin
        ic_n = '0;
        if (oc_idx < out_ch - 1'b1) begin
          oc_n = oc_idx + 1'b1;
          nxt  = ISSUE;
        end else nxt = DONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are flops loaded from the next-state decode so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idle      <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      eng_start <= 1'b0;
      ic_idx    <= '0;
      oc_idx    <= '0;
      bias_en   <= 1'b0;
      acc_en    <= 1'b0;
      acc_load  <= 1'b0;
      och_valid <= 1'b0;
      in_ch     <= '0;
      out_ch    <= '0;
      wd        <= '0;
    end else begin
      state     <= nxt;
      ic_idx    <= ic_n;
      oc_idx    <= oc_n;
      idle      <= nxt == IDLE;
      done      <= nxt == DONE;
      eng_start <= state == ISSUE && eng_idle;
      acc_en    <= nxt == ACC;
      acc_load  <= nxt == ACC && ic_idx == '0;
      och_valid <= nxt == OUT;
      bias_en   <= (nxt == ISSUE || nxt == WAIT || nxt == ACC || nxt == OUT) && ic_n == '0;
      wd        <= state == WAIT ? wd + 1'b1 : '0;
      if (state == IDLE && start) begin
        in_ch  <= cfg_in_ch;
        out_ch <= cfg_out_ch;
        err    <= 1'b0;
      end else if (state == WAIT && !eng_finish && wd_hit) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched: directed scenarios against a 10-cycle engine model.
module tb_conv_layer_sched;
  logic clk = 0, rst_n = 0, start = 0, och_ready = 1;
  logic [7:0] cfg_in_ch = 0, cfg_out_ch = 0;
  logic idle, done, err, eng_start, eng_idle, eng_finish, bias_en, acc_en, acc_load, och_valid;
  logic [7:0] ic_idx, oc_idx;
  int errors = 0, checks = 0;
  int cnt = 0, cyc = 0;
  logic fin_r = 0, spur = 0, idle_block = 0, hang = 0;
  int n_start = 0, n_acc = 0, n_load = 0, n_loadbad = 0, n_hs = 0, n_done = 0;
  int n_vcyc = 0, n_unstable = 0, n_overlap = 0, vrun = 0, done_cyc = 0, st_cyc = 0;
  logic [7:0] v_oc = 0;
  logic [7:0] s_oc [256];
  logic [7:0] s_ic [256];
  logic       s_bias [256];
  int         s_cyc [256];
  int         runs [16];

  conv_layer_sched #(.CH_W(8), .TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
    .idle(idle), .done(done), .err(err), .eng_start(eng_start), .eng_idle(eng_idle),
    .eng_finish(eng_finish), .ic_idx(ic_idx), .oc_idx(oc_idx), .bias_en(bias_en),
    .acc_en(acc_en), .acc_load(acc_load), .och_valid(och_valid), .och_ready(och_ready)
  );

  always #5 clk = ~clk;
  assign eng_idle   = (cnt == 0) && !idle_block;
  assign eng_finish = fin_r | spur;

  // Engine: busy from the eng_start cycle, finish pulse 10 cycles later.
  initial forever begin
    @(posedge clk);
    #1;
    fin_r = 0;
    if (!rst_n) cnt = 0;
    else if (eng_start && !hang) cnt = 10;
    else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) fin_r = 1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (eng_start) begin
      if (n_start < 256) begin
        s_oc[n_start] = oc_idx;
        s_ic[n_start] = ic_idx;
        s_bias[n_start] = bias_en;
        s_cyc[n_start] = cyc;
      end
      if (och_valid) n_overlap++;
      n_start++;
    end
    if (acc_en) begin
      n_acc++;
      if (acc_load) n_load++;
      if (acc_load !== (ic_idx == 0)) n_loadbad++;
    end
    if (och_valid) begin
      if (vrun > 0 && oc_idx !== v_oc) n_unstable++;
      v_oc = oc_idx;
      vrun++;
      n_vcyc++;
      if (och_ready) begin
        if (n_hs < 16) runs[n_hs] = vrun;
        n_hs++;
        vrun = 0;
      end
    end else vrun = 0;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i_ch, input int o_ch);
    cfg_in_ch = 8'(i_ch);
    cfg_out_ch = 8'(o_ch);
    start = 1;
    st_cyc = cyc + 1;
    tick(1);
    start = 0;
  endtask

  task automatic wait_done(input int base, input int max);
    for (int i = 0; i < max && n_done == base; i++) tick(1);
    checks++;
    if (n_done == base) begin
      errors++;
      $display("FAIL wait_done: no done within %0d cycles", max);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    tick(3);
    checks++;
    if ({idle, done, err, eng_start, bias_en, acc_en, acc_load, och_valid} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 10000000", {idle, done, err, eng_start, bias_en, acc_en, acc_load, och_valid});
    end
    checks++;
    if ({ic_idx, oc_idx} !== 16'h0) begin
      errors++;
      $display("FAIL reset_idx: got ic=%0d oc=%0d want 0 0", ic_idx, oc_idx);
    end
    rst_n = 1;
    tick(2);
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_after: got %b want 1", idle);
    end
  endtask

  task automatic test_basic;
    int bs, ba, bl, blb, bh, bd;
    logic [16:0] exp_v;
    bs = n_start; ba = n_acc; bl = n_load; blb = n_loadbad; bh = n_hs; bd = n_done;
    och_ready = 1;
    pulse_start(3, 2);
    wait_done(bd, 1000);
    tick(2);
    checks++;
    if (n_start - bs != 6) begin
      errors++;
      $display("FAIL basic_starts: got %0d want 6", n_start - bs);
    end
    for (int k = 0; k < 6; k++) begin
      exp_v = {8'(k / 3), 8'(k % 3), k % 3 == 0};
      checks++;
      if ({s_oc[bs+k], s_ic[bs+k], s_bias[bs+k]} !== exp_v) begin
        errors++;
        $display("FAIL basic_order[%0d]: got oc=%0d ic=%0d bias=%b want oc=%0d ic=%0d bias=%b",
                 k, s_oc[bs+k], s_ic[bs+k], s_bias[bs+k], exp_v[16:9], exp_v[8:1], exp_v[0]);
      end
    end
    checks++;
    if ((s_cyc[bs+1] - s_cyc[bs] < 12) || (s_cyc[bs+4] - s_cyc[bs+3] < 12)) begin
      errors++;
      $display("FAIL basic_gap: got %0d/%0d want >=12", s_cyc[bs+1] - s_cyc[bs], s_cyc[bs+4] - s_cyc[bs+3]);
    end
    checks++;
    if (n_acc - ba != 6 || n_load - bl != 2 || n_loadbad != blb) begin
      errors++;
      $display("FAIL basic_acc: got acc=%0d load=%0d bad=%0d want 6 2 0", n_acc - ba, n_load - bl, n_loadbad - blb);
    end
    checks++;
    if (n_hs - bh != 2 || n_done - bd != 1) begin
      errors++;
      $display("FAIL basic_hs_done: got hs=%0d done=%0d want 2 1", n_hs - bh, n_done - bd);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL basic_err: got %b want 0", err);
    end
  endtask

  task automatic test_backpressure;
    int bs, bh, bu, bo, bd;
    bs = n_start; bh = n_hs; bu = n_unstable; bo = n_overlap; bd = n_done;
    och_ready = 0;
    pulse_start(3, 2);
    repeat (2) begin
      for (int i = 0; i < 300 && !och_valid; i++) tick(1);
      checks++;
      if (och_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_valid_seen: got %b want 1", och_valid);
      end
      tick(5);
      och_ready = 1;
      tick(1);
      och_ready = 0;
    end
    wait_done(bd, 300);
    och_ready = 1;
    checks++;
    if (runs[bh] != 6 || runs[bh+1] != 6) begin
      errors++;
      $display("FAIL bp_valid_len: got %0d,%0d want 6,6", runs[bh], runs[bh+1]);
    end
    checks++;
    if (n_unstable != bu || n_overlap != bo) begin
      errors++;
      $display("FAIL bp_stability: got unstable=%0d overlap=%0d want 0 0", n_unstable - bu, n_overlap - bo);
    end
    checks++;
    if (n_start - bs != 6) begin
      errors++;
      $display("FAIL bp_starts: got %0d want 6", n_start - bs);
    end
  endtask

  task automatic test_zero_cfg;
    int bs, ba, bv, bd;
    bs = n_start; ba = n_acc; bv = n_vcyc; bd = n_done;
    pulse_start(0, 4);
    tick(4);
    checks++;
    if (n_done - bd != 1 || done_cyc - st_cyc != 1) begin
      errors++;
      $display("FAIL zero_done: got count=%0d delay=%0d want 1 1", n_done - bd, done_cyc - st_cyc);
    end
    checks++;
    if (n_start != bs || n_acc != ba || n_vcyc != bv) begin
      errors++;
      $display("FAIL zero_activity: got starts=%0d acc=%0d valid=%0d want 0 0 0", n_start - bs, n_acc - ba, n_vcyc - bv);
    end
    checks++;
    if ({idle, err} !== 2'b10) begin
      errors++;
      $display("FAIL zero_idle_err: got %b want 10", {idle, err});
    end
  endtask

  task automatic test_timeout;
    int bs, ba, bd, bh;
    bs = n_start; ba = n_acc; bd = n_done;
    hang = 1;
    pulse_start(1, 1);
    wait_done(bd, 200);
    hang = 0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL to_err: got %b want 1", err);
    end
    checks++;
    if (n_start - bs != 1 || done_cyc - s_cyc[bs] != 16) begin
      errors++;
      $display("FAIL to_delay: got starts=%0d delay=%0d want 1 16", n_start - bs, done_cyc - s_cyc[bs]);
    end
    checks++;
    if (n_acc != ba) begin
      errors++;
      $display("FAIL to_acc: got %0d want 0", n_acc - ba);
    end
    bs = n_start; bd = n_done; bh = n_hs;
    pulse_start(1, 1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL to_err_clear: got %b want 0", err);
    end
    wait_done(bd, 200);
    checks++;
    if (n_start - bs != 1 || n_hs - bh != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL to_rerun: got starts=%0d hs=%0d err=%b want 1 1 0", n_start - bs, n_hs - bh, err);
    end
  endtask

  task automatic test_idle_stall;
    int bs, ba, bh, bd;
    bs = n_start; ba = n_acc; bh = n_hs; bd = n_done;
    idle_block = 1;
    pulse_start(2, 1);
    tick(2);
    spur = 1;
    tick(1);
    spur = 0;
    cfg_in_ch = 3;
    cfg_out_ch = 3;
    start = 1;
    tick(1);
    start = 0;
    tick(3);
    idle_block = 0;
    wait_done(bd, 300);
    checks++;
    if (s_cyc[bs] - st_cyc != 9) begin
      errors++;
      $display("FAIL stall_first_start: got delay=%0d want 9", s_cyc[bs] - st_cyc);
    end
    checks++;
    if (n_start - bs != 2 || n_acc - ba != 2 || n_hs - bh != 1 || n_done - bd != 1) begin
      errors++;
      $display("FAIL stall_counts: got starts=%0d acc=%0d hs=%0d done=%0d want 2 2 1 1",
               n_start - bs, n_acc - ba, n_hs - bh, n_done - bd);
    end
    checks++;
    if ({s_oc[bs+1], s_ic[bs+1]} !== {8'd0, 8'd1}) begin
      errors++;
      $display("FAIL stall_second_idx: got oc=%0d ic=%0d want 0 1", s_oc[bs+1], s_ic[bs+1]);
    end
  endtask

  task automatic test_reset_mid;
    int bs, bd, bh;
    bs = n_start; bd = n_done;
    pulse_start(2, 2);
    for (int i = 0; i < 500 && n_start - bs < 4; i++) tick(1);
    checks++;
    if (n_start - bs != 4 || {s_oc[bs+3], s_ic[bs+3]} !== {8'd1, 8'd1}) begin
      errors++;
      $display("FAIL mid_reach_job11: got starts=%0d want 4 at (1,1)", n_start - bs);
    end
    tick(3);
    rst_n = 0;
    #1;
    checks++;
    if ({idle, done, err, eng_start, bias_en, acc_en, acc_load, och_valid, ic_idx, oc_idx} !== {8'b1000_0000, 16'h0}) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b %0d %0d want 10000000 0 0",
               {idle, done, err, eng_start, bias_en, acc_en, acc_load, och_valid}, ic_idx, oc_idx);
    end
    tick(2);
    rst_n = 1;
    tick(1);
    checks++;
    if (n_done != bd) begin
      errors++;
      $display("FAIL mid_no_done: got %0d want 0", n_done - bd);
    end
    bs = n_start; bd = n_done; bh = n_hs;
    pulse_start(1, 1);
    wait_done(bd, 200);
    checks++;
    if (n_start - bs != 1 || n_hs - bh != 1 || err !== 1'b0 || {s_oc[bs], s_ic[bs]} !== 16'h0) begin
      errors++;
      $display("FAIL mid_rerun: got starts=%0d hs=%0d err=%b want 1 1 0", n_start - bs, n_hs - bh, err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_cfg();
    test_timeout();
    test_idle_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
